// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multi-cycle sequencer for the MIPS datapath. Each instruction is split into
// FETCH / DECODE / EXECUTE / MEM / WB steps, and every datapath control strobe
// comes from this block. One memory port is shared between instruction fetch
// and data access. mem_ready tells the sequencer that the current access is
// complete.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   opcode[5:0]    IR[31:26], sampled in DECODE only
//   zero           ALU zero flag (the datapath ANDs it with pc_write_cond)
//   mem_ready      memory completed the current read/write this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if zero
//   i_or_d         memory address select: 0 = PC, 1 = ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       instruction register load
//   memto_reg      write-back source: 1 = MDR
//   reg_dst        destination select: 1 = rd, 0 = rt
//   reg_write      register file write enable
//   alu_src_a      ALU A: 0 = PC, 1 = A register
//   alu_src_b[1:0] ALU B: 00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op[1:0]    00 = add, 01 = subtract, 10 = funct field
//   pc_source[1:0] 00 = ALU result, 01 = ALUOut, 10 = jump target
//   state[3:0]     current state (debug)
//   illegal_op     pulse during DECODE of an undecodable opcode
//   instr_count    retired-instruction counter, wraps
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter bit MEM_WAIT_EN = 1'b1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             memto_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   state_t           state_q, state_d;
   // lw and sw share MEM_ADDR, so the store/load choice is remembered
   // from DECODE. The opcode is not looked at again after DECODE.
   logic             is_store_q, is_store_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rdy;
   logic             retire;

   // With wait states disabled every access completes in one cycle.
   assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

   // zero is consumed by the datapath together with pc_write_cond.
   // The sequencer itself never branches on it.
   logic unused_zero;
   assign unused_zero = zero;

   always_comb begin
      state_d       = state_q;
      is_store_d    = is_store_q;
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      memto_reg     = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            // PC+4 and the IR load only take effect once the fetch returns.
            pc_write  = rdy;
            ir_write  = rdy;
            if (rdy) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            unique case (opcode)
               6'b000000: state_d = S_EXECUTE;
               6'b100011: begin state_d = S_MEM_ADDR; is_store_d = 1'b0; end
               6'b101011: begin state_d = S_MEM_ADDR; is_store_d = 1'b1; end
               6'b000100: state_d = S_BRANCH;
               6'b000010: state_d = S_JUMP;
               6'b001000: state_d = S_ADDI_EXEC;
               default: begin
                  state_d    = S_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = is_store_q ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (rdy) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write = 1'b1;
            memto_reg = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (rdy) state_d = S_FETCH;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = S_FETCH;
         end
         S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Only a completed instruction returning to FETCH counts. An illegal
      // opcode also returns from DECODE, but it does not retire.
      if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_DECODE)
         retire = 1'b1;
      cnt_d = cnt_q + CNT_W'(retire);

      // While reset is held, every strobe is silenced, including the
      // FETCH strobes that the reset state would otherwise drive.
      if (!reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         i_or_d        = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         memto_reg     = 1'b0;
         reg_dst       = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         alu_op        = 2'b00;
         pc_source     = 2'b00;
         illegal_op    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_FETCH;
         is_store_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         cnt_q      <= cnt_d;
      end
   end

   assign state       = state_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Scoreboard bench for the multi-cycle controller. For every cycle it drives,
// the stimulus side pushes the expected state, control vector and counter.
// A negedge monitor pops each entry and compares it with the DUT outputs.
// The DUT is built with CNT_W=4 so that counter wrap can be reached quickly.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic [5:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
   logic             ir_write, memto_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]       alu_src_b, alu_op, pc_source;
   logic [3:0]       state;
   logic             illegal_op;
   logic [CNT_W-1:0] instr_count;

   mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .memto_reg     (memto_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .state         (state),
      .illegal_op    (illegal_op),
      .instr_count   (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
   //  memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
   //  pc_source, illegal_op}
   logic [20:0] act_vec;
   assign act_vec = {state, pc_write, pc_write_cond, i_or_d, mem_read,
                     mem_write, ir_write, memto_reg, reg_dst, reg_write,
                     alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

   typedef struct {
      string            tag;
      logic [20:0]      vec;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t             sb[$];
   exp_t             cur;
   logic [CNT_W-1:0] exp_cnt;
   int               n_checks = 0;
   int               n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Expected strobes for a state, taken from the per-state output table.
   function automatic logic [20:0] exp_vec(input int st, input bit mr,
                                           input bit ill, input bit rst_n);
      logic       pw, pwc, iod, mrd, mwr, irw, mtr, rdst, rw, asa;
      logic [1:0] asb, aop, psrc;
      {pw, pwc, iod, mrd, mwr, irw, mtr, rdst, rw, asa} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         0:  begin mrd = 1; asb = 2'b01; pw = mr; irw = mr; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; iod = 1; end
         4:  begin rw = 1; mtr = 1; end
         5:  begin mwr = 1; iod = 1; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rdst = 1; end
         8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
         9:  begin pw = 1; psrc = 2'b10; end
         10: begin asa = 1; asb = 2'b10; end
         11: rw = 1;
         default: ;
      endcase
      if (!rst_n) return 21'd0;
      return {4'(st), pw, pwc, iod, mrd, mwr, irw, mtr, rdst, rw, asa,
              asb, aop, psrc, ill};
   endfunction

   // One clock cycle: drive the inputs, push the expectation, and advance.
   // Outside DECODE the opcode is random, because it must be ignored there.
   task automatic cyc(input string tag, input int st, input bit mr,
                      input logic [5:0] op, input bit ill, input bit rst_n);
      exp_t e;
      reset     = rst_n;
      mem_ready = mr;
      zero      = 1'($urandom);
      opcode    = (st == 1) ? op : 6'($urandom);
      if (!rst_n) exp_cnt = '0;
      e.tag = $sformatf("%s st%0d", tag, st);
      e.vec = exp_vec(st, mr, ill, rst_n);
      e.cnt = exp_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Expected state walk of a whole instruction, with optional wait cycles
   // in FETCH (fw) and in the data-memory state (mw).
   task automatic exec(input string name, input logic [5:0] op,
                       input int fw, input int mw);
      bit ill;
      ill = 1'b0;
      for (int i = 0; i < fw; i++) cyc(name, 0, 1'b0, op, 1'b0, 1'b1);
      cyc(name, 0, 1'b1, op, 1'b0, 1'b1);
      case (op)
         6'b000000: ;
         6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000: ;
         default: ill = 1'b1;
      endcase
      cyc(name, 1, 1'b1, op, ill, 1'b1);
      case (op)
         6'b000000: begin cyc(name, 6, 1'b1, op, 0, 1); cyc(name, 7, 1'b1, op, 0, 1); end
         6'b100011: begin
            cyc(name, 2, 1'b1, op, 0, 1);
            for (int i = 0; i < mw; i++) cyc(name, 3, 1'b0, op, 0, 1);
            cyc(name, 3, 1'b1, op, 0, 1);
            cyc(name, 4, 1'b1, op, 0, 1);
         end
         6'b101011: begin
            cyc(name, 2, 1'b1, op, 0, 1);
            for (int i = 0; i < mw; i++) cyc(name, 5, 1'b0, op, 0, 1);
            cyc(name, 5, 1'b1, op, 0, 1);
         end
         6'b000100: cyc(name, 8, 1'b1, op, 0, 1);
         6'b000010: cyc(name, 9, 1'b1, op, 0, 1);
         6'b001000: begin cyc(name, 10, 1'b1, op, 0, 1); cyc(name, 11, 1'b1, op, 0, 1); end
         default: ;
      endcase
      if (!ill) exp_cnt = exp_cnt + 1'b1;
      $display("instr %-10s op=%b fw=%0d mw=%0d -> expected count %0d",
               name, op, fw, mw, exp_cnt);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         check({cur.tag, " ctrl"}, 32'(act_vec), 32'(cur.vec));
         check({cur.tag, " cnt"}, 32'(instr_count), 32'(cur.cnt));
      end
   end

   initial begin
      reset     = 1'b0;
      mem_ready = 1'b1;
      opcode    = 6'd0;
      zero      = 1'b0;
      exp_cnt   = '0;
      @(posedge clk);
      #1;
      cyc("reset", 0, 1'b1, 6'd0, 1'b0, 1'b0);
      cyc("reset", 0, 1'b1, 6'd0, 1'b0, 1'b0);

      exec("rtype", 6'b000000, 0, 0);
      exec("lw_wait", 6'b100011, 0, 2);
      exec("beq", 6'b000100, 0, 0);
      exec("sw", 6'b101011, 0, 0);
      exec("illegal", 6'b111111, 0, 0);
      exec("j", 6'b000010, 0, 0);
      exec("addi", 6'b001000, 0, 0);
      exec("lw", 6'b100011, 1, 0);
      exec("sw_wait", 6'b101011, 0, 1);
      exec("illegal2", 6'b000001, 0, 0);

      // Abort a store stalled in MEM_WRITE by asserting reset.
      cyc("sw_abort", 0, 1'b1, 6'b101011, 1'b0, 1'b1);
      cyc("sw_abort", 1, 1'b1, 6'b101011, 1'b0, 1'b1);
      cyc("sw_abort", 2, 1'b1, 6'b101011, 1'b0, 1'b1);
      cyc("sw_abort", 5, 1'b0, 6'b101011, 1'b0, 1'b1);
      cyc("sw_abort", 5, 1'b0, 6'b101011, 1'b0, 1'b0);
      exec("post_rst", 6'b000000, 2, 0);

      // Run enough R-type instructions for the 4-bit counter to wrap.
      for (int i = 0; i < 16; i++) exec("wrap", 6'b000000, 0, 0);

      @(negedge clk);
      #1;
      check("final_cnt", 32'(instr_count), 32'(exp_cnt));
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
